// File: rtl/mac_pkg.sv
// Shared definitions for the MAC dot-product sequencer: state encodings,
// default datapath widths and the 2x2 Vedic building block.
package mac_pkg;

  localparam int unsigned DefDataW = 4;
  localparam int unsigned DefAccW  = 8;
  localparam int unsigned DefCntW  = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Urdhva-Tiryagbhyam 2x2 multiply: vertical and crosswise partial products.
  function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
    logic p0, p1, c1, p2, p3;
    p0 = a[0] & b[0];
    p1 = (a[1] & b[0]) ^ (a[0] & b[1]);
    c1 = (a[1] & b[0]) & (a[0] & b[1]);
    p2 = (a[1] & b[1]) ^ c1;
    p3 = (a[1] & b[1]) & c1;
    return {p3, p2, p1, p0};
  endfunction

endpackage

// File: rtl/mac_accum_unit.sv
// Multiply-accumulate datapath: acc += a*b on en, with a sticky carry-out flag.
module mac_accum_unit
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clr,
  input  logic              en,
  output logic [ACC_W-1:0]  acc,
  output logic              carry
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                carry_q, carry_d;

  if (DATA_W == 4) begin : g_vedic
    vedic_mult4x4 u_mult (
      .a (a),
      .b (b),
      .p (prod)
    );
  end else begin : g_generic
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  end

  assign sum = {1'b0, acc_q} + (ACC_W + 1)'(prod);

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clr) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (en) begin
      acc_d   = sum[ACC_W-1:0];
      carry_d = carry_q | sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign acc   = acc_q;
  assign carry = carry_q;

endmodule

// File: rtl/vedic_mult4x4.sv
// 4x4 unsigned Vedic multiplier assembled from four 2x2 Vedic blocks.
module vedic_mult4x4
  import mac_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] q_ll, q_hl, q_lh, q_hh;

  assign q_ll = vedic_2x2(a[1:0], b[1:0]);
  assign q_hl = vedic_2x2(a[3:2], b[1:0]);
  assign q_lh = vedic_2x2(a[1:0], b[3:2]);
  assign q_hh = vedic_2x2(a[3:2], b[3:2]);

  // Cross terms land at weight 4, the high-high term at weight 16.
  assign p = 8'(q_ll) + (8'(q_hl) << 2) + (8'(q_lh) << 2) + (8'(q_hh) << 4);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Job sequencer for the MAC datapath: takes len operand pairs over valid/ready
// and returns the dot product with a sticky overflow flag.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             acc_clr, acc_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = len;
          acc_clr = 1'b1;
          if (len == '0) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (in_valid) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          // The last beat is folded in on the same edge that enters DONE.
          if (cnt_q == CNT_W'(1)) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  mac_accum_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (in_a),
    .b     (in_b),
    .clr   (acc_clr),
    .en    (acc_en),
    .acc   (out_acc),
    .carry (out_ovf)
  );

  assign in_ready  = (state_q == StRun);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized self-checking bench for mac_dot_sequencer against a sum-of-products model.
module tb_mac_dot_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_acc;
  logic       out_ovf;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  int fix_a[16];
  int fix_b[16];

  always #5 clk = ~clk;

  mac_dot_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke_noise(input bit noise);
    if (noise) begin
      start = 1'b1;
      len   = 4'($urandom);
    end
  endtask

  // mode: 0 continuous valid, 1 three-cycle bubbles, 2 random valid.
  task automatic run_job(input int l, input int mode, input int hold, input bit noise,
                         input bit fixed);
    int sum   = 0;
    int beats = 0;
    int edges = 0;
    int gap   = 0;
    int guard = 0;
    int exp_acc, exp_ovf, av, bv;
    bit v;
    @(negedge clk);
    start = 1'b1; len = 4'(l); in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    poke_noise(noise);
    check("busy_after_start", busy, 1);
    while (beats < l && guard < 200) begin
      check("in_ready_run", in_ready, 1);
      check("out_valid_run", out_valid, 0);
      case (mode)
        0:       v = 1'b1;
        1:       v = (gap == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      gap = (gap == 3) ? 0 : gap + 1;
      av = fixed ? fix_a[beats] : int'($urandom_range(0, 15));
      bv = fixed ? fix_b[beats] : int'($urandom_range(0, 15));
      in_valid = v; in_a = 4'(av); in_b = 4'(bv);
      @(posedge clk);
      edges++;
      if (v) begin
        sum += av * bv;
        beats++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      poke_noise(noise);
      guard++;
    end
    if (guard >= 200) check("run_timeout", 0, 1);
    if (mode == 0) check("done_latency", edges, l);
    exp_acc = sum % 256;
    exp_ovf = (sum >= 256) ? 1 : 0;
    for (int i = 0; i <= hold; i++) begin
      check("out_valid_done", out_valid, 1);
      check("in_ready_done", in_ready, 0);
      check("busy_done", busy, 1);
      check("out_acc", out_acc, exp_acc);
      check("out_ovf", out_ovf, exp_ovf);
      if (i < hold) begin
        in_valid = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        poke_noise(noise);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("out_valid_idle", out_valid, 0);
    check("busy_idle", busy, 0);
    check("in_ready_idle", in_ready, 0);
  endtask

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    fix_a[0] = 2;  fix_b[0] = 3;
    fix_a[1] = 4;  fix_b[1] = 5;
    fix_a[2] = 1;  fix_b[2] = 1;
    run_job(3, 0, 0, 1'b0, 1'b1);

    fix_a[0] = 15; fix_b[0] = 15;
    fix_a[1] = 15; fix_b[1] = 15;
    run_job(2, 0, 0, 1'b0, 1'b1);

    run_job(2, 1, 5, 1'b0, 1'b0);
    run_job(0, 0, 1, 1'b0, 1'b0);

    // Reset in the middle of a three-beat job after one beat.
    @(negedge clk);
    start = 1'b1; len = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = 4'd7; in_b = 4'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_acc", out_acc, 0);
    check("midrst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fix_a[0] = 3; fix_b[0] = 3;
    run_job(1, 0, 0, 1'b0, 1'b1);

    run_job(5, 2, 3, 1'b1, 1'b0);
    run_job(15, 0, 2, 1'b1, 1'b0);

    for (int j = 0; j < 25; j++) begin
      run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
